// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants and register-file types.
package cpu_pkg;

    localparam int unsigned DATA_W     = 8;
    localparam int unsigned REG_ADDR_W = 4;
    localparam int unsigned NUM_REGS   = 16;
    localparam int unsigned ZERO_REG   = 0;

    typedef logic [DATA_W-1:0]     reg_data_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/gp_regfile_rdport.sv
// Register-file read port: masks R0 and out-of-range addresses.
// With GP_REGFILE_BYPASS_EN defined, it also forwards same-cycle write data.
module gp_regfile_rdport #(
    parameter int unsigned DATA_W   = cpu_pkg::DATA_W,
    parameter int unsigned ADDR_W   = cpu_pkg::REG_ADDR_W,
    parameter int unsigned NUM_REGS = cpu_pkg::NUM_REGS
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] raw_data,
`ifdef GP_REGFILE_BYPASS_EN
    input  logic              fwd_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
`endif
    output logic [DATA_W-1:0] data_c
);
    import cpu_pkg::ZERO_REG;

    localparam logic [ADDR_W:0] NUM_REGS_W = (ADDR_W+1)'(NUM_REGS);

    logic addr_ok;
    logic [DATA_W-1:0] stored;

    assign addr_ok = (addr != ADDR_W'(ZERO_REG)) && ({1'b0, addr} < NUM_REGS_W);
    assign stored  = addr_ok ? raw_data : '0;

`ifdef GP_REGFILE_BYPASS_EN
    // fwd_en already implies a valid, nonzero write address
    assign data_c = (fwd_en && (addr == wr_addr)) ? wr_data : stored;
`else
    assign data_c = stored;
`endif

endmodule

// File: rtl/gp_regfile.sv
// General-purpose register file: two combinational read ports, one write port, R0 = 0.
// Optional write-to-read forwarding is enabled by defining GP_REGFILE_BYPASS_EN.
module gp_regfile #(
    parameter int unsigned DATA_W   = cpu_pkg::DATA_W,
    parameter int unsigned ADDR_W   = cpu_pkg::REG_ADDR_W,
    parameter int unsigned NUM_REGS = cpu_pkg::NUM_REGS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rs_addr,
    output logic [DATA_W-1:0] rs_data,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rt_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack
);
    import cpu_pkg::ZERO_REG;

    localparam logic [ADDR_W:0] NUM_REGS_W = (ADDR_W+1)'(NUM_REGS);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [DATA_W-1:0] rs_raw;
    logic [DATA_W-1:0] rt_raw;
    logic              wr_valid;

    assign wr_valid = wr_en && (wr_addr != ADDR_W'(ZERO_REG)) && ({1'b0, wr_addr} < NUM_REGS_W);

    // Storage and write acknowledge; R0 is never written so it holds its reset zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            wr_ack <= 1'b0;
        end else begin
            wr_ack <= wr_valid;
            for (int i = 1; i < NUM_REGS; i++) begin
                if (wr_valid && (wr_addr == ADDR_W'(i))) begin
                    regs[i] <= wr_data;
                end
            end
        end
    end

    // Array lookup by decode so out-of-range addresses never index past the array
    always_comb begin
        rs_raw = '0;
        rt_raw = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rs_addr == ADDR_W'(i)) rs_raw = regs[i];
            if (rt_addr == ADDR_W'(i)) rt_raw = regs[i];
        end
    end

    gp_regfile_rdport #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .NUM_REGS(NUM_REGS)
    ) u_rs_port (
        .addr    (rs_addr),
        .raw_data(rs_raw),
`ifdef GP_REGFILE_BYPASS_EN
        .fwd_en  (wr_valid),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
`endif
        .data_c  (rs_data)
    );

    gp_regfile_rdport #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .NUM_REGS(NUM_REGS)
    ) u_rt_port (
        .addr    (rt_addr),
        .raw_data(rt_raw),
`ifdef GP_REGFILE_BYPASS_EN
        .fwd_en  (wr_valid),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
`endif
        .data_c  (rt_data)
    );

endmodule

// File: tb/tb_gp_regfile.sv
// Self-checking bench for gp_regfile: vector table, corner sequences, randomized model check.
module tb_gp_regfile;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] rs_addr = '0, rt_addr = '0, wr_addr = '0;
    logic [7:0] rs_data, rt_data, wr_data = '0;
    logic       wr_en = 1'b0;
    logic       wr_ack;

    logic [3:0] rs_addr12 = '0, rt_addr12 = '0, wr_addr12 = '0;
    logic [7:0] rs_data12, rt_data12, wr_data12 = '0;
    logic       wr_en12 = 1'b0;
    logic       wr_ack12;

    int checks = 0;
    int errors = 0;

`ifdef GP_REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    always #5 clk = ~clk;

    gp_regfile u_dut (
        .clk(clk), .rst_n(rst_n),
        .rs_addr(rs_addr), .rs_data(rs_data),
        .rt_addr(rt_addr), .rt_data(rt_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ack(wr_ack)
    );

    gp_regfile #(.DATA_W(8), .ADDR_W(4), .NUM_REGS(12)) u_dut12 (
        .clk(clk), .rst_n(rst_n),
        .rs_addr(rs_addr12), .rs_data(rs_data12),
        .rt_addr(rt_addr12), .rt_data(rt_data12),
        .wr_en(wr_en12), .wr_addr(wr_addr12), .wr_data(wr_data12),
        .wr_ack(wr_ack12)
    );

    typedef struct {
        logic       we;
        logic [3:0] wa;
        logic [7:0] wd;
        logic [3:0] ra;
        logic [3:0] rb;
        logic [7:0] exp_rs;
        logic [7:0] exp_rt;
        logic       exp_ack;
    } vec_t;

    vec_t vecs [8];
    logic [7:0] mem [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic we, input logic [3:0] wa, input logic [7:0] wd,
                         input logic [3:0] ra, input logic [3:0] rb);
        wr_en = we; wr_addr = wa; wr_data = wd; rs_addr = ra; rt_addr = rb;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] model_read(input logic [3:0] a, input logic we,
                                              input logic [3:0] wa, input logic [7:0] wd);
        if (a == 4'd0) return 8'h00;
        if (BYPASS && we && wa != 4'd0 && wa == a) return wd;
        return mem[a];
    endfunction

    initial begin
        logic [7:0] alu_in1, alu_in2;

        vecs[0] = '{1'b1, 4'd5,  8'hA5, 4'd5,  4'd0,  8'hA5, 8'h00, 1'b1};
        vecs[1] = '{1'b1, 4'd9,  8'h3C, 4'd5,  4'd9,  8'hA5, 8'h3C, 1'b1};
        vecs[2] = '{1'b1, 4'd0,  8'hFF, 4'd0,  4'd0,  8'h00, 8'h00, 1'b0};
        vecs[3] = '{1'b0, 4'd5,  8'h77, 4'd5,  4'd9,  8'hA5, 8'h3C, 1'b0};
        vecs[4] = '{1'b1, 4'd1,  8'hF0, 4'd1,  4'd5,  8'hF0, 8'hA5, 1'b1};
        vecs[5] = '{1'b1, 4'd2,  8'h0F, 4'd1,  4'd2,  8'hF0, 8'h0F, 1'b1};
        vecs[6] = '{1'b1, 4'd9,  8'h00, 4'd9,  4'd9,  8'h00, 8'h00, 1'b1};
        vecs[7] = '{1'b1, 4'd15, 8'hC3, 4'd15, 4'd14, 8'hC3, 8'h00, 1'b1};

        // Reset held: every address reads zero on both ports
        #2;
        for (int a = 0; a < 16; a++) begin
            rs_addr = 4'(a);
            rt_addr = 4'(15 - a);
            #1;
            check($sformatf("reset_rs[%0d]", a), 32'(rs_data), 32'h00);
            check($sformatf("reset_rt[%0d]", 15 - a), 32'(rt_data), 32'h00);
        end
        check("reset_ack", 32'(wr_ack), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_reset_ack", 32'(wr_ack), 32'h0);

        // Vector table: values checked after the write edge
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ra, vecs[i].rb);
            tick();
            check($sformatf("vec%0d_ack", i), 32'(wr_ack), 32'(vecs[i].exp_ack));
            check($sformatf("vec%0d_rs", i), 32'(rs_data), 32'(vecs[i].exp_rs));
            check($sformatf("vec%0d_rt", i), 32'(rt_data), 32'(vecs[i].exp_rt));
        end

        // ALU OR of R1 and R2 written back into R4
        drive(1'b0, 4'd0, 8'h00, 4'd1, 4'd2);
        #1;
        alu_in1 = rs_data;
        alu_in2 = rt_data;
        check("alu_in1", 32'(alu_in1), 32'hF0);
        check("alu_in2", 32'(alu_in2), 32'h0F);
        drive(1'b1, 4'd4, alu_in1 | alu_in2, 4'd4, 4'd1);
        tick();
        drive(1'b0, 4'd0, 8'h00, 4'd4, 4'd1);
        #1;
        check("alu_r4", 32'(rs_data), 32'hFF);

        // Same-cycle read of R3 while it is being overwritten
        drive(1'b1, 4'd3, 8'h11, 4'd0, 4'd0);
        tick();
        drive(1'b1, 4'd3, 8'h22, 4'd3, 4'd3);
        #1;
        check("r3_same_cycle_rs", 32'(rs_data), BYPASS ? 32'h22 : 32'h11);
        check("r3_same_cycle_rt", 32'(rt_data), BYPASS ? 32'h22 : 32'h11);
        tick();
        drive(1'b0, 4'd0, 8'h00, 4'd3, 4'd0);
        #1;
        check("r3_next_cycle", 32'(rs_data), 32'h22);

        // Forwarding never applies to R0
        drive(1'b1, 4'd0, 8'hEE, 4'd0, 4'd0);
        #1;
        check("r0_no_forward", 32'(rs_data), 32'h00);
        tick();
        check("r0_drop_ack", 32'(wr_ack), 32'h0);
        drive(1'b0, 4'd0, 8'h00, 4'd0, 4'd0);

        // 12-register instance: out-of-range and R0 writes are dropped
        wr_en12 = 1'b1; wr_addr12 = 4'd14; wr_data12 = 8'hAA; rs_addr12 = 4'd14; rt_addr12 = 4'd11;
        #1;
        check("n12_oor_same_cycle", 32'(rs_data12), 32'h00);
        tick();
        check("n12_oor_ack", 32'(wr_ack12), 32'h0);
        check("n12_oor_read", 32'(rs_data12), 32'h00);
        wr_addr12 = 4'd11; wr_data12 = 8'h55;
        tick();
        check("n12_r11_ack", 32'(wr_ack12), 32'h1);
        check("n12_r11_read", 32'(rt_data12), 32'h55);
        wr_addr12 = 4'd0; wr_data12 = 8'hFF; rs_addr12 = 4'd0;
        tick();
        check("n12_r0_ack", 32'(wr_ack12), 32'h0);
        check("n12_r0_read", 32'(rs_data12), 32'h00);
        wr_en12 = 1'b0;

        // Asynchronous reset between edges, with a write attempted during reset
        drive(1'b1, 4'd7, 8'h5A, 4'd7, 4'd7);
        tick();
        drive(1'b0, 4'd0, 8'h00, 4'd7, 4'd7);
        #1;
        check("r7_written", 32'(rs_data), 32'h5A);
        check("r7_ack", 32'(wr_ack), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_r7", 32'(rs_data), 32'h00);
        check("async_rst_ack", 32'(wr_ack), 32'h0);
        drive(1'b1, 4'd7, 8'h5A, 4'd7, 4'd3);
        tick();
        check("rst_write_r7", 32'(rs_data), 32'h00);
        check("rst_write_r3", 32'(rt_data), 32'h00);
        check("rst_write_ack", 32'(wr_ack), 32'h0);
        drive(1'b0, 4'd0, 8'h00, 4'd7, 4'd3);
        #3;
        rst_n = 1'b1;
        tick();
        check("post_rst_r7", 32'(rs_data), 32'h00);
        check("post_rst_ack", 32'(wr_ack), 32'h0);

        // Randomized traffic against the array model
        for (int a = 0; a < 16; a++) mem[a] = 8'h00;
        for (int n = 0; n < 400; n++) begin
            logic       we;
            logic [3:0] wa, ra, rb;
            logic [7:0] wd;
            we = ($urandom_range(3) != 0);
            wa = 4'($urandom_range(15));
            wd = 8'($urandom);
            ra = ($urandom_range(3) == 0) ? wa : 4'($urandom_range(15));
            rb = ($urandom_range(3) == 0) ? wa : 4'($urandom_range(15));
            drive(we, wa, wd, ra, rb);
            #1;
            check($sformatf("rnd%0d_rs", n), 32'(rs_data), 32'(model_read(ra, we, wa, wd)));
            check($sformatf("rnd%0d_rt", n), 32'(rt_data), 32'(model_read(rb, we, wa, wd)));
            tick();
            if (we && wa != 4'd0) mem[wa] = wd;
            check($sformatf("rnd%0d_ack", n), 32'(wr_ack), 32'(we && wa != 4'd0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
